// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU BIST driver: opcode encodings, rotation table,
// polynomial constant and sequencer state type.
package alu_bist_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam int unsigned NUM_OPS = 6;

   // Entry 0 is the rightmost element, so the rotation starts at AND.
   localparam logic [NUM_OPS-1:0][3:0] OP_TABLE = {OP_NOR, OP_SLT, OP_SUB,
                                                   OP_ADD, OP_OR, OP_AND};

   localparam logic [63:0] POLY64 = 64'h1B;

   typedef enum logic [2:0] {
      StIdle,
      StSeed,
      StRun,
      StDrain,
      StDone
   } state_e;

   // One Galois step of x^64+x^4+x^3+x+1; shared by the LFSRs and the MISR.
   function automatic logic [63:0] poly_step(input logic [63:0] v);
      return (v << 1) ^ (v[63] ? POLY64 : 64'h0);
   endfunction

endpackage

// File: rtl/lfsr64_galois.sv
// 64-bit Galois LFSR with synchronous seed load and an advance enable.
module lfsr64_galois
   import alu_bist_pkg::*;
#(
   parameter logic [63:0] RESET_VAL = 64'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [63:0] seed,
   input  logic        advance,
   output logic [63:0] value
);

   logic [63:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = seed;
      end else if (advance) begin
         value_d = poly_step(value_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= RESET_VAL;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/alu_bist_driver.sv
// BIST sequencer for the 64-bit ALU: drives LFSR operands with a rotating opcode,
// compacts the responses into a MISR and compares it against a golden signature.
module alu_bist_driver
   import alu_bist_pkg::*;
#(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [63:0] SEED_A      = 64'h0000_0000_0000_0001,
   parameter logic [63:0] SEED_B      = 64'hDEAD_BEEF_CAFE_F00D
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] golden_sig,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [3:0]       OP,
   input  logic [WIDTH-1:0] O,
   input  logic             Ovf,
   input  logic             Zero,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature,
   output logic [15:0]      vec_count
);

   localparam logic [15:0] LastVec = 16'(NUM_VECTORS - 1);

   state_e      state_q, state_d;
   logic [63:0] a_q, a_d, b_q, b_d, sig_q, sig_d;
   logic [3:0]  op_q, op_d;
   logic [2:0]  op_idx_q, op_idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic        pass_q, pass_d;

   logic        lfsr_load, lfsr_adv;
   logic [63:0] lfsr_a, lfsr_b;

   assign lfsr_load = (state_q == StSeed);
   assign lfsr_adv  = (state_q == StRun);

   lfsr64_galois #(
      .RESET_VAL (SEED_A)
   ) u_lfsr_a (
      .clk     (clk),
      .rst     (rst),
      .load    (lfsr_load),
      .seed    (SEED_A),
      .advance (lfsr_adv),
      .value   (lfsr_a)
   );

   lfsr64_galois #(
      .RESET_VAL (SEED_B)
   ) u_lfsr_b (
      .clk     (clk),
      .rst     (rst),
      .load    (lfsr_load),
      .seed    (SEED_B),
      .advance (lfsr_adv),
      .value   (lfsr_b)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      op_idx_d = op_idx_q;
      sig_d    = sig_q;
      cnt_d    = cnt_q;
      pass_d   = pass_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StSeed;
         end
         StSeed: begin
            a_d      = SEED_A;
            b_d      = SEED_B;
            op_idx_d = 3'd0;
            op_d     = OP_TABLE[0];
            sig_d    = 64'h0;
            cnt_d    = 16'h0;
            pass_d   = 1'b0;
            state_d  = StRun;
         end
         StRun: begin
            // Capture the response to the vector on A/B/OP while driving the next one.
            sig_d    = poly_step(sig_q) ^ O ^ {62'b0, Ovf, Zero};
            a_d      = poly_step(lfsr_a);
            b_d      = poly_step(lfsr_b);
            op_idx_d = (op_idx_q == 3'(NUM_OPS - 1)) ? 3'd0 : 3'(op_idx_q + 3'd1);
            op_d     = OP_TABLE[op_idx_d];
            cnt_d    = 16'(cnt_q + 16'd1);
            if (cnt_q == LastVec) begin
               state_d = StDone;
               pass_d  = (sig_d == golden_sig);
            end
         end
         StDone: begin
            if (start) state_d = StSeed;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= 64'h0;
         b_q      <= 64'h0;
         op_q     <= 4'h0;
         op_idx_q <= 3'd0;
         sig_q    <= 64'h0;
         cnt_q    <= 16'h0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         op_idx_q <= op_idx_d;
         sig_q    <= sig_d;
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
      end
   end

   assign A         = a_q;
   assign B         = b_q;
   assign OP        = op_q;
   assign signature = sig_q;
   assign vec_count = cnt_q;
   assign busy      = (state_q == StSeed) || (state_q == StRun) || (state_q == StDrain);
   assign done      = (state_q == StDone);
   assign pass      = pass_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: a 6-vector and a 1-vector instance, each wired to a
// behavioural ALU, checked against a vector/signature model built from the algorithm.
module tb_alu_bist_driver;

   localparam logic [63:0] SA = 64'h0000_0000_0000_0001;
   localparam logic [63:0] SB = 64'hDEAD_BEEF_CAFE_F00D;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 6-vector instance
   logic        start6;
   logic [63:0] gold6, a6, b6, o6, sig6;
   logic [3:0]  op6;
   logic        ovf6, zero6, busy6, done6, pass6;
   logic [15:0] cnt6;
   logic        fault_on;
   logic [15:0] fault_idx;

   // 1-vector instance
   logic        start1;
   logic [63:0] gold1, a1, b1, o1, sig1;
   logic [3:0]  op1;
   logic        ovf1, zero1, busy1, done1, pass1;
   logic [15:0] cnt1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] exp_a [7];
   logic [63:0] exp_b [7];
   logic [3:0]  exp_op [7];

   alu_bist_driver #(
      .WIDTH       (64),
      .NUM_VECTORS (6),
      .SEED_A      (SA),
      .SEED_B      (SB)
   ) dut6 (
      .clk        (clk),
      .rst        (rst),
      .start      (start6),
      .golden_sig (gold6),
      .A          (a6),
      .B          (b6),
      .OP         (op6),
      .O          (o6),
      .Ovf        (ovf6),
      .Zero       (zero6),
      .busy       (busy6),
      .done       (done6),
      .pass       (pass6),
      .signature  (sig6),
      .vec_count  (cnt6)
   );

   alu_bist_driver #(
      .WIDTH       (64),
      .NUM_VECTORS (1),
      .SEED_A      (SA),
      .SEED_B      (SB)
   ) dut1 (
      .clk        (clk),
      .rst        (rst),
      .start      (start1),
      .golden_sig (gold1),
      .A          (a1),
      .B          (b1),
      .OP         (op1),
      .O          (o1),
      .Ovf        (ovf1),
      .Zero       (zero1),
      .busy       (busy1),
      .done       (done1),
      .pass       (pass1),
      .signature  (sig1),
      .vec_count  (cnt1)
   );

   // Behavioural ALU: returns {ovf, zero, result}.
   function automatic logic [65:0] alu(input logic [63:0] a, input logic [63:0] b,
                                       input logic [3:0] op);
      logic [63:0] o;
      logic        v;
      o = 64'h0;
      v = 1'b0;
      case (op)
         4'b0000: o = a & b;
         4'b0001: o = a | b;
         4'b0010: begin
            o = a + b;
            v = (a[63] == b[63]) && (o[63] != a[63]);
         end
         4'b0110: begin
            o = a - b;
            v = (a[63] != b[63]) && (o[63] != a[63]);
         end
         4'b0111: o = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'b1100: o = ~(a | b);
         default: o = 64'h0;
      endcase
      return {v, (o == 64'h0), o};
   endfunction

   function automatic logic [63:0] step(input logic [63:0] v);
      return (v << 1) ^ (v[63] ? 64'h1B : 64'h0);
   endfunction

   // Expected signature after n vectors, optionally with Zero forced on vector fidx.
   function automatic logic [63:0] model_sig(input bit fen, input int fidx, input int n);
      logic [63:0] s;
      logic [65:0] r;
      logic        z;
      s = 64'h0;
      for (int k = 0; k < n; k++) begin
         r = alu(exp_a[k], exp_b[k], exp_op[k]);
         z = r[64] | (fen && (k == fidx));
         s = step(s) ^ r[63:0] ^ {62'b0, r[65], z};
      end
      return s;
   endfunction

   always_comb begin
      {ovf6, zero6, o6} = alu(a6, b6, op6);
      if (fault_on && busy6 && (cnt6 == fault_idx)) zero6 = 1'b1;
   end

   always_comb begin
      {ovf1, zero1, o1} = alu(a1, b1, op1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero6(input string tag);
      chk({tag, "_a"}, a6, 64'h0);
      chk({tag, "_b"}, b6, 64'h0);
      chk({tag, "_op"}, {60'h0, op6}, 64'h0);
      chk({tag, "_sig"}, sig6, 64'h0);
      chk({tag, "_cnt"}, {48'h0, cnt6}, 64'h0);
      chk({tag, "_flags"}, {61'h0, busy6, done6, pass6}, 64'h0);
   endtask

   // One run of the 6-vector instance. glitch_k: vector at which start is pulsed
   // mid-run (-1 none). abort_k: vector at which reset is applied (-1 none).
   task automatic run6(input bit fen, input int fidx, input logic [63:0] gold,
                       input int glitch_k, input int abort_k);
      logic [63:0] es;
      @(negedge clk);
      gold6     = gold;
      fault_on  = fen;
      fault_idx = 16'(fidx);
      start6    = 1'b1;
      @(negedge clk);
      start6 = 1'b0;
      chk("seed_busy", {63'h0, busy6}, 64'h1);
      chk("seed_done", {63'h0, done6}, 64'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("vec_a", a6, exp_a[k]);
         chk("vec_b", b6, exp_b[k]);
         chk("vec_op", {60'h0, op6}, {60'h0, exp_op[k]});
         chk("vec_cnt", {48'h0, cnt6}, 64'(k));
         chk("run_done", {63'h0, done6}, 64'h0);
         if (k == abort_k) begin
            rst    = 1'b1;
            start6 = 1'b1;
            #1;
            chk_zero6("abort");
            @(negedge clk);
            chk_zero6("rst_vs_start");
            rst    = 1'b0;
            start6 = 1'b0;
            return;
         end
         start6 = (k == glitch_k);
      end
      @(negedge clk);
      start6 = 1'b0;
      es = model_sig(fen, fidx, 6);
      chk("end_done", {63'h0, done6}, 64'h1);
      chk("end_busy", {63'h0, busy6}, 64'h0);
      chk("end_cnt", {48'h0, cnt6}, 64'd6);
      chk("end_sig", sig6, es);
      chk("end_pass", {63'h0, pass6}, {63'h0, (es == gold)});
      chk("end_a_hold", a6, exp_a[6]);
      chk("end_op_hold", {60'h0, op6}, {60'h0, exp_op[6]});
   endtask

   task automatic run1(input logic [63:0] gold);
      logic [63:0] es;
      @(negedge clk);
      gold1  = gold;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("n1_seed_busy", {63'h0, busy1}, 64'h1);
      @(negedge clk);
      chk("n1_a", a1, exp_a[0]);
      chk("n1_op", {60'h0, op1}, {60'h0, exp_op[0]});
      chk("n1_run_done", {63'h0, done1}, 64'h0);
      @(negedge clk);
      es = model_sig(1'b0, 0, 1);
      chk("n1_done", {63'h0, done1}, 64'h1);
      chk("n1_cnt", {48'h0, cnt1}, 64'd1);
      chk("n1_sig", sig1, es);
      chk("n1_pass", {63'h0, pass1}, {63'h0, (es == gold)});
   endtask

   initial begin
      logic [3:0]  ops [6];
      logic [63:0] gold_ok, gold_rnd;
      int          fidx, gk;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
      exp_a[0] = SA;
      exp_b[0] = SB;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) begin
            exp_a[k] = step(exp_a[k-1]);
            exp_b[k] = step(exp_b[k-1]);
         end
         exp_op[k] = ops[k % 6];
      end

      rst       = 1'b1;
      start6    = 1'b0;
      start1    = 1'b0;
      gold6     = 64'h0;
      gold1     = 64'h0;
      fault_on  = 1'b0;
      fault_idx = 16'h0;
      #2;
      chk_zero6("reset");
      chk("reset_n1", {sig1[63:1], busy1 | done1 | pass1}, 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      gold_ok = model_sig(1'b0, 0, 6);
      run6(1'b0, 0, gold_ok, -1, -1);

      // Vectors 0..3 never produce a natural zero, so forcing Zero must change the MISR.
      fidx = $urandom_range(0, 3);
      run6(1'b1, fidx, gold_ok, -1, -1);

      run6(1'b0, 0, gold_ok, -1, 3);
      run6(1'b0, 0, gold_ok, -1, -1);

      gk = $urandom_range(0, 5);
      run6(1'b0, 0, gold_ok, gk, -1);

      gold_rnd = {$urandom, $urandom};
      run6(1'b0, 0, gold_rnd, -1, -1);

      repeat (3) @(negedge clk);
      chk("done_hold", {63'h0, done6}, 64'h1);
      chk("done_a_hold", a6, exp_a[6]);
      chk("done_b_hold", b6, exp_b[6]);

      run1({$urandom, $urandom});
      run1(model_sig(1'b0, 0, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
